// File: rtl/execute_muldiv.sv
// Iterative RV64M/RV32M multiply/divide unit beside the execute-stage ALU.
// Latency: MUL W/MUL_BITS+1 cycles, DIV W+1 cycles, divide special cases 1 cycle (W = 32 or XLEN).
// Backpressure: one op at a time; in_ready only in IDLE; result held in DONE until out_ready.
module execute_muldiv #(
    parameter int XLEN     = 64,
    parameter int MUL_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic [4:0]      in_rd,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = 2 * XLEN;

    // Sign-extend a 32-bit value to the full datapath width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     acc_q, acc_d;     // product accumulator
    logic [PW-1:0]     opa_q, opa_d;     // multiplicand, shifted left each MUL cycle
    logic [XLEN-1:0]   opb_q, opb_d;     // multiplier (MUL) or divisor (DIV)
    logic [XLEN-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]   rem_q, rem_d;     // partial remainder
    logic [XLEN-1:0]   result_q, result_d;

    // operand preparation
    logic              op_word, s1_signed, s2_signed, sign1, sign2;
    logic [XLEN-1:0]   x1, x2, mag1, mag2, min_w, zero_rem;
    logic              div_zero, div_ovf;

    // per-cycle iteration and final fix-up
    logic [PW-1:0]     partial, acc_step, prod_s;
    logic [XLEN-1:0]   rem_shift, rem_step, quo_step, quo_s, rem_s;
    logic              rem_ge;
    logic [XLEN-1:0]   mul_res, div_res;

    // Extend operands for the W variants, take magnitudes, detect divide special cases.
    always_comb begin
        op_word   = (XLEN == 64) && in_word && ((in_op == 3'b000) || in_op[2]);
        s1_signed = (in_op == 3'b001) || (in_op == 3'b010) || (in_op == 3'b100) || (in_op == 3'b110);
        s2_signed = (in_op == 3'b001) || (in_op == 3'b100) || (in_op == 3'b110);
        x1 = in_src1;
        x2 = in_src2;
        if (op_word) begin
            x1       = '0;
            x1[31:0] = in_src1[31:0];
            x2       = '0;
            x2[31:0] = in_src2[31:0];
            if (s1_signed) x1 = sext32(in_src1[31:0]);
            if (s2_signed) x2 = sext32(in_src2[31:0]);
        end
        sign1    = s1_signed && x1[XLEN-1];
        sign2    = s2_signed && x2[XLEN-1];
        mag1     = sign1 ? -x1 : x1;
        mag2     = sign2 ? -x2 : x2;
        min_w    = op_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (x2 == '0);
        div_ovf  = !in_op[0] && (x1 == min_w) && (x2 == '1);
        zero_rem = op_word ? sext32(in_src1[31:0]) : in_src1;
    end

    // One radix-2^MUL_BITS shift-add step and one restoring-division step.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (opb_q[i]) partial = partial + (opa_q << i);
        end
        acc_step = acc_q + partial;

        // The bit shifted out of rem_q is the 2^XLEN weight of the shifted remainder.
        rem_shift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
        rem_ge    = rem_q[XLEN-1] || (rem_shift >= opb_q);
        rem_step  = rem_ge ? (rem_shift - opb_q) : rem_shift;
        quo_step  = {quo_q[XLEN-2:0], rem_ge};
    end

    // Sign fix-up and result selection on the final iteration values.
    always_comb begin
        prod_s = neg_q ? -acc_step : acc_step;
        if (op_q[1:0] == 2'b00) begin
            mul_res = word_q ? sext32(prod_s[31:0]) : prod_s[XLEN-1:0];
        end else begin
            mul_res = prod_s[PW-1:XLEN];
        end
        quo_s   = neg_q ? -quo_step : quo_step;
        rem_s   = neg_q ? -rem_step : rem_step;
        div_res = op_q[1] ? rem_s : quo_s;
        if (word_q) div_res = sext32(div_res[31:0]);
    end

    // Next-state logic: accept, iterate, hold result; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d   = in_op;
                    word_d = op_word;
                    rd_d   = in_rd;
                    opb_d  = mag2;
                    if (in_op[2]) begin
                        neg_d = in_op[1] ? sign1 : (sign1 ^ sign2);
                        if (div_zero) begin
                            result_d = in_op[1] ? zero_rem : '1;
                            state_d  = ST_DONE;
                        end else if (div_ovf) begin
                            result_d = in_op[1] ? '0 : x1;
                            state_d  = ST_DONE;
                        end else begin
                            // Word dividends are left-aligned so the top bit enters first.
                            quo_d   = op_word ? (mag1 << (XLEN - 32)) : mag1;
                            rem_d   = '0;
                            cnt_d   = op_word ? CW'(31) : CW'(XLEN - 1);
                            state_d = ST_DIV;
                        end
                    end else begin
                        neg_d   = sign1 ^ sign2;
                        acc_d   = '0;
                        opa_d   = {{XLEN{1'b0}}, mag1};
                        cnt_d   = op_word ? CW'(32 / MUL_BITS - 1) : CW'(XLEN / MUL_BITS - 1);
                        state_d = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                acc_d = acc_step;
                opa_d = opa_q << MUL_BITS;
                opb_d = opb_q >> MUL_BITS;
                if (cnt_q == '0) begin
                    result_d = mul_res;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DIV: begin
                quo_d = quo_step;
                rem_d = rem_step;
                if (cnt_q == '0) begin
                    result_d = div_res;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) state_d = ST_IDLE;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            word_q   <= 1'b0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = result_q;
    assign out_rd     = rd_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: directed corner cases plus random ops vs a reference model.
// Latency: measured per op from the accept edge to out_valid.
// Backpressure: holds out_ready low in DONE, exercises flush and reset mid-operation.
module tb_execute_muldiv;

    localparam int XLEN = 64;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_word, busy, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1, in_src2, out_result;
    logic [4:0]  in_rd, out_rd;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    execute_muldiv #(.XLEN(XLEN), .MUL_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_word    (in_word),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_rd      (in_rd),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: RISC-V M-extension semantics with wide arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] wa, wb;
        logic [31:0]        ua, ub;
        logic               w;
        w  = word && ((op == 3'b000) || op[2]);
        sa = a;  sb = b;
        wa = a[31:0]; wb = b[31:0];
        ua = a[31:0]; ub = b[31:0];
        case (op)
            3'd0: begin
                p = {64'b0, a} * {64'b0, b};
                return w ? sx32(p[31:0]) : p[63:0];
            end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b};       return p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b};             return p[127:64]; end
            3'd4: begin
                if (w) begin
                    if (ub == 0) return '1;
                    if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx32(ua);
                    return sx32(wa / wb);
                end
                if (b == 0) return '1;
                if (a == MIN64 && b == '1) return a;
                return sa / sb;
            end
            3'd5: begin
                if (w) return (ub == 0) ? '1 : sx32(ua / ub);
                return (b == 0) ? '1 : a / b;
            end
            3'd6: begin
                if (w) begin
                    if (ub == 0) return sx32(ua);
                    if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return '0;
                    return sx32(wa % wb);
                end
                if (b == 0) return a;
                if (a == MIN64 && b == '1) return '0;
                return sa % sb;
            end
            default: begin
                if (w) return (ub == 0) ? sx32(ua) : sx32(ua % ub);
                return (b == 0) ? a : a % b;
            end
        endcase
    endfunction

    // Cycles from the accepting edge to the first cycle with out_valid.
    function automatic int exp_lat(input logic [2:0] op, input logic word,
                                   input logic [63:0] a, input logic [63:0] b);
        logic w, zero, ovf;
        w = word && ((op == 3'b000) || op[2]);
        if (!op[2]) return w ? 9 : 17;
        zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
        ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == MIN64 && b == '1));
        return (zero || ovf) ? 1 : (w ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return MIN64;
            3:       return {$urandom, 32'h8000_0000};
            4:       return 64'($urandom_range(0, 20));
            5:       return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic word,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int hold);
        int         lat;
        logic       done;
        logic [4:0] rd;
        rd = 5'($urandom_range(1, 31));
        @(negedge clk);
        chk({name, ".in_ready"}, in_ready, 64'd1);
        in_valid = 1'b1; in_op = op; in_word = word;
        in_src1 = a; in_src2 = b; in_rd = rd;
        @(posedge clk);
        #1;
        // Scramble the request bus so a unit that fails to latch is caught.
        in_valid = 1'b0;
        in_src1 = {$urandom, $urandom};
        in_src2 = {$urandom, $urandom};
        in_op   = 3'($urandom);
        in_rd   = 5'($urandom);
        lat  = 1;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (out_valid || lat >= 200) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        chk({name, ".latency"}, 64'(lat), 64'(exp_lat(op, word, a, b)));
        chk({name, ".result"}, out_result, exp);
        chk({name, ".rd"}, out_rd, rd);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({name, ".hold_result"}, out_result, exp);
            chk({name, ".hold_in_ready"}, in_ready, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, ".ready_after"}, in_ready, 64'd1);
        chk({name, ".valid_after"}, out_valid, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_word = 1'b0; in_src1 = '0; in_src2 = '0; in_rd = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.in_ready", in_ready, 64'd1);
        chk("reset.busy", busy, 64'd0);
        chk("reset.out_valid", out_valid, 64'd0);
        chk("reset.out_result", out_result, 64'd0);
        chk("reset.out_rd", out_rd, 64'd0);

        // Directed corner cases with hand-derived results.
        run_op("mul_7x-3",   3'd0, 1'b0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 10);
        run_op("mulhu_max",  3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("mulh_m1",    3'd1, 1'b0, '1, '1, 64'h0, 0);
        run_op("mulhsu_m1",  3'd2, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("mulw_ovf",   3'd0, 1'b1, 64'h8000_0000, 64'd2, 64'h0, 0);
        run_op("mulw_max",   3'd0, 1'b1, 64'h7FFF_FFFF, 64'h7FFF_FFFF, 64'h1, 0);
        run_op("mulh_word",  3'd1, 1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 0);
        run_op("div_-7/2",   3'd4, 1'b0, -64'd7, 64'd2, -64'd3, 0);
        run_op("rem_-7/2",   3'd6, 1'b0, -64'd7, 64'd2, -64'd1, 0);
        run_op("divu_100/7", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 0);
        run_op("remu_100/7", 3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 0);
        run_op("div_by0",    3'd4, 1'b0, 64'd123, 64'd0, '1, 0);
        run_op("rem_5/0",    3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 0);
        run_op("div_ovf",    3'd4, 1'b0, MIN64, '1, MIN64, 0);
        run_op("rem_ovf",    3'd6, 1'b0, MIN64, '1, 64'd0, 0);
        run_op("divw_ovf",   3'd4, 1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 0);
        run_op("divw_20/-3", 3'd4, 1'b1, 64'd20, 64'h0000_0000_FFFF_FFFD, -64'd6, 0);
        run_op("remuw_by0",  3'd7, 1'b1, 64'h1_8000_0007, 64'h5_0000_0000, 64'hFFFF_FFFF_8000_0007, 0);

        // Random ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            run_op("rand", op, w, a, b, model(op, w, a, b), 0);
        end

        // Flush five cycles into a divide: never completes, idle next cycle.
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd5; in_word = 1'b0; in_src1 = 64'd100; in_src2 = 64'd7; in_rd = 5'd9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush.busy", busy, 64'd0);
        chk("flush.in_ready", in_ready, 64'd1);
        chk("flush.out_valid", out_valid, 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush.no_result", 64'(seen), 64'd0);

        // Request presented with flush is dropped.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_op = 3'd4; in_src1 = 64'd9; in_src2 = 64'd0;
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("flush_req.busy", busy, 64'd0);
        @(negedge clk);
        chk("flush_req.out_valid", out_valid, 64'd0);

        // Reset in the middle of a multiply.
        run_op("mul_pre_rst", 3'd0, 1'b0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_word = 1'b0; in_src1 = 64'd5; in_src2 = 64'd6; in_rd = 5'd17;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_mid.busy_before", busy, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.busy", busy, 64'd0);
        chk("rst_mid.in_ready", in_ready, 64'd1);
        chk("rst_mid.out_valid", out_valid, 64'd0);
        chk("rst_mid.out_result", out_result, 64'd0);
        chk("rst_mid.out_rd", out_rd, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
